// File: rtl/spi_slave_fsm_if.sv
// Register-side bus between the SPI target endpoint and a local register block.
interface spi_slave_fsm_if #(
    parameter int unsigned DATA_W = 16
) ();
    logic [7:0]        reg_addr;
    logic              reg_wr_en;
    logic [DATA_W-1:0] reg_wr_data;
    logic              reg_rd_en;
    logic [DATA_W-1:0] reg_rd_data;

    modport master (
        output reg_addr,
        output reg_wr_en,
        output reg_wr_data,
        output reg_rd_en,
        input  reg_rd_data
    );

    modport slave (
        input  reg_addr,
        input  reg_wr_en,
        input  reg_wr_data,
        input  reg_rd_en,
        output reg_rd_data
    );
endinterface

// File: rtl/spi_slave_fsm.sv
// SPI mode-0 target: oversamples the SPI pins, decodes 16-bit command / 16-bit data
// frames into register read/write strobes and shifts read data back on MISO.
module spi_slave_fsm #(
    parameter int unsigned CMD_W       = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk_in,
    input  logic mosi_in,
    input  logic cs_n_in,
    output logic miso_out,
    output logic miso_oe,
    output logic busy,
    output logic frame_done,
    output logic frame_err,
    spi_slave_fsm_if.master reg_if
);
    localparam int unsigned MAX_W  = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int unsigned CNT_W  = $clog2(MAX_W);
    localparam int unsigned ADDR_W = 8;

    typedef enum logic [2:0] {
        WAIT_IDLE, IDLE, CMD, DATA_WR, DATA_RD, DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [CMD_W-2:0]       cmd_sr_q, cmd_sr_d;
    logic [DATA_W-2:0]      data_sr_q, data_sr_d;
    logic [DATA_W-1:0]      tx_sr_q, tx_sr_d;
    logic                   rd_cap_q, rd_cap_d;
    logic                   miso_q, miso_d;
    logic                   oe_q, oe_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   wr_en_q, wr_en_d;
    logic [DATA_W-1:0]      wr_data_q, wr_data_d;
    logic                   rd_en_q, rd_en_d;

    logic sclk_s, mosi_s, cs_s;
    logic sclk_rise, sclk_fall, cs_fall;
    logic abort;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n_in};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        bit_cnt_d   = bit_cnt_q;
        cmd_sr_d    = cmd_sr_q;
        data_sr_d   = data_sr_q;
        tx_sr_d     = tx_sr_q;
        rd_cap_d    = rd_en_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        addr_d      = addr_q;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        rd_en_d     = 1'b0;
        abort       = 1'b0;

        unique case (state_q)
            WAIT_IDLE: begin
                if (cs_s) state_d = IDLE;
            end
            IDLE: begin
                if (cs_fall) begin
                    state_d   = CMD;
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                    oe_d      = 1'b1;
                    miso_d    = 1'b0;
                end
            end
            CMD: begin
                if (cs_s) begin
                    abort = 1'b1;
                end else if (sclk_rise) begin
                    cmd_sr_d  = {cmd_sr_q[CMD_W-3:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(CMD_W - 1)) begin
                        bit_cnt_d = '0;
                        addr_d    = {cmd_sr_q[ADDR_W-2:0], mosi_s};
                        if (cmd_sr_q[CMD_W-2]) begin
                            rd_en_d = 1'b1;
                            state_d = DATA_RD;
                        end else begin
                            state_d = DATA_WR;
                        end
                    end
                end
            end
            DATA_WR: begin
                // A final rise coinciding with deselect still completes the write.
                if (sclk_rise && bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = {data_sr_q, mosi_s};
                    state_d   = DONE;
                end else if (cs_s) begin
                    abort = 1'b1;
                end else if (sclk_rise) begin
                    data_sr_d = {data_sr_q[DATA_W-3:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            DATA_RD: begin
                if (sclk_rise && bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                    miso_d  = 1'b0;
                    state_d = DONE;
                end else if (cs_s) begin
                    abort = 1'b1;
                end else begin
                    if (sclk_rise) bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (rd_cap_q) begin
                        tx_sr_d = reg_if.reg_rd_data;
                    end else if (sclk_fall) begin
                        miso_d  = tx_sr_q[DATA_W-1];
                        tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
            DONE: begin
                miso_d = 1'b0;
                if (cs_s) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    oe_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase

        if (abort) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            oe_d    = 1'b0;
            miso_d  = 1'b0;
            state_d = IDLE;
        end
    end

    // cs_n synchronizer resets to "selected" so a mid-frame reset waits for a real deselect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_IDLE;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            bit_cnt_q   <= '0;
            cmd_sr_q    <= '0;
            data_sr_q   <= '0;
            tx_sr_q     <= '0;
            rd_cap_q    <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            rd_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_sync_q   <= cs_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_sr_q    <= cmd_sr_d;
            data_sr_q   <= data_sr_d;
            tx_sr_q     <= tx_sr_d;
            rd_cap_q    <= rd_cap_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            rd_en_q     <= rd_en_d;
        end
    end

    assign miso_out           = miso_q;
    assign miso_oe            = oe_q;
    assign busy               = busy_q;
    assign frame_done         = done_q;
    assign frame_err          = err_q;
    assign reg_if.reg_addr    = addr_q;
    assign reg_if.reg_wr_en   = wr_en_q;
    assign reg_if.reg_wr_data = wr_data_q;
    assign reg_if.reg_rd_en   = rd_en_q;
endmodule

// File: tb/tb_spi_slave_fsm.sv
// Directed bench for spi_slave_fsm: bit-banged SPI master, small register model,
// strobe counters and immediate-assertion checks.
module tb_spi_slave_fsm;
    localparam int H   = 8;   // SCLK half-period in clk cycles
    localparam int GAP = 10;

    logic clk, rst, sclk_in, mosi_in, cs_n_in;
    logic miso_out, miso_oe, busy, frame_done, frame_err;

    spi_slave_fsm_if #(.DATA_W(16)) rif ();

    spi_slave_fsm #(.CMD_W(16), .DATA_W(16), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk_in    (sclk_in),
        .mosi_in    (mosi_in),
        .cs_n_in    (cs_n_in),
        .miso_out   (miso_out),
        .miso_oe    (miso_oe),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .reg_if     (rif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Register model and strobe monitors
    logic [15:0] regs [256];
    logic        model_clr;
    int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, err_cnt = 0, miso_hi = 0;

    always @(negedge clk) begin
        if (model_clr) begin
            for (int i = 0; i < 256; i++) regs[i] <= 16'h0000;
            regs[8'h34] <= 16'h1234;
        end else if (rif.reg_wr_en) begin
            regs[rif.reg_addr] <= rif.reg_wr_data;
        end
        if (rif.reg_wr_en) wr_cnt   <= wr_cnt + 1;
        if (rif.reg_rd_en) rd_cnt   <= rd_cnt + 1;
        if (frame_done)    done_cnt <= done_cnt + 1;
        if (frame_err)     err_cnt  <= err_cnt + 1;
        if (miso_out)      miso_hi  <= miso_hi + 1;
    end

    always @(posedge clk) begin
        if (rif.reg_rd_en) rif.reg_rd_data <= regs[rif.reg_addr];
    end

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One SPI frame, mode 0, MSB first; bits past 32 drive MOSI high.
    task automatic spi_frame(input logic [15:0] cmd, input logic [15:0] data,
                             input int nbits, input int rst_bit,
                             input bit exp_wr, input bit exp_done, input int gap,
                             output logic [15:0] rx);
        logic [31:0] word;
        word = {cmd, data};
        rx   = 16'h0000;
        cs_n_in = 1'b0;
        clk_wait(H);
        for (int i = 0; i < nbits; i++) begin
            mosi_in = (i < 32) ? word[31-i] : 1'b1;
            if (i == rst_bit) begin
                rst = 1'b1;
                clk_wait(1);
                rst = 1'b0;
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_oe", {31'd0, miso_oe}, 32'd0);
                clk_wait(H - 1);
            end else begin
                clk_wait(H);
            end
            if (i == 16 && rst_bit < 0) begin
                chk("mid_busy", {31'd0, busy}, 32'd1);
                chk("mid_oe", {31'd0, miso_oe}, 32'd1);
            end
            sclk_in = 1'b1;
            if (i >= 16 && i < 32) rx = {rx[14:0], miso_out};
            if (i == 31 && exp_wr) begin
                clk_wait(2);
                chk("wr_early", {31'd0, rif.reg_wr_en}, 32'd0);
                clk_wait(1);
                chk("wr_lat", {31'd0, rif.reg_wr_en}, 32'd1);
                chk("wr_addr", {24'd0, rif.reg_addr}, {24'd0, cmd[7:0]});
                chk("wr_data", {16'd0, rif.reg_wr_data}, {16'd0, data});
                clk_wait(H - 3);
            end else begin
                clk_wait(H);
            end
            sclk_in = 1'b0;
        end
        clk_wait(H);
        cs_n_in = 1'b1;
        if (exp_done) begin
            clk_wait(2);
            chk("done_early", {31'd0, frame_done}, 32'd0);
            clk_wait(1);
            chk("done_lat", {31'd0, frame_done}, 32'd1);
            clk_wait(gap - 3);
        end else begin
            clk_wait(gap);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] rx;
        int hi_base;
        rst = 1'b1; cs_n_in = 1'b1; sclk_in = 1'b0; mosi_in = 1'b0;
        model_clr = 1'b1;
        rif.reg_rd_data = 16'h0000;
        clk_wait(3);
        chk("rst_miso", {31'd0, miso_out}, 32'd0);
        chk("rst_oe0", {31'd0, miso_oe}, 32'd0);
        chk("rst_busy0", {31'd0, busy}, 32'd0);
        chk("rst_strobes", {28'd0, rif.reg_wr_en, rif.reg_rd_en, frame_done, frame_err}, 32'd0);
        chk("rst_addr", {24'd0, rif.reg_addr}, 32'd0);
        chk("rst_wdata", {16'd0, rif.reg_wr_data}, 32'd0);
        rst = 1'b0; model_clr = 1'b0;
        clk_wait(5);

        // Plain write
        hi_base = miso_hi;
        spi_frame(16'h0012, 16'hA5C3, 32, -1, 1'b1, 1'b1, GAP, rx);
        chk("w1_wr_cnt", wr_cnt, 1);
        chk("w1_rd_cnt", rd_cnt, 0);
        chk("w1_done", done_cnt, 1);
        chk("w1_miso", miso_hi - hi_base, 0);
        chk("w1_reg", {16'd0, regs[8'h12]}, 32'h0000A5C3);
        chk("w1_busy", {31'd0, busy}, 32'd0);

        // Plain read
        spi_frame(16'h8034, 16'h0000, 32, -1, 1'b0, 1'b1, GAP, rx);
        chk("r1_rx", {16'd0, rx}, 32'h00001234);
        chk("r1_rd_cnt", rd_cnt, 1);
        chk("r1_wr_cnt", wr_cnt, 1);
        chk("r1_addr", {24'd0, rif.reg_addr}, 32'h34);
        chk("r1_oe", {31'd0, miso_oe}, 32'd0);

        // Abort after 10 command bits, then a normal write
        spi_frame(16'h0056, 16'h0000, 10, -1, 1'b0, 1'b0, GAP, rx);
        chk("ab_err", err_cnt, 1);
        chk("ab_wr", wr_cnt, 1);
        chk("ab_rd", rd_cnt, 1);
        chk("ab_done", done_cnt, 2);
        chk("ab_busy", {31'd0, busy}, 32'd0);
        spi_frame(16'h0001, 16'hFFFF, 32, -1, 1'b1, 1'b1, GAP, rx);
        chk("ab2_reg", {16'd0, regs[8'h01]}, 32'h0000FFFF);
        chk("ab2_wr", wr_cnt, 2);

        // Back-to-back with minimal deselect gap
        spi_frame(16'h0005, 16'hBEEF, 32, -1, 1'b1, 1'b1, 6, rx);
        spi_frame(16'h8005, 16'h0000, 32, -1, 1'b0, 1'b1, GAP, rx);
        chk("bb_rx", {16'd0, rx}, 32'h0000BEEF);
        chk("bb_cnts", {wr_cnt[7:0], rd_cnt[7:0], done_cnt[7:0], err_cnt[7:0]}, 32'h03020501);

        // Reset during write data phase
        spi_frame(16'h0033, 16'h1111, 32, 20, 1'b0, 1'b0, GAP, rx);
        chk("rs_wr", wr_cnt, 3);
        chk("rs_done", done_cnt, 5);
        chk("rs_err", err_cnt, 1);
        chk("rs_reg", {16'd0, regs[8'h33]}, 32'd0);
        spi_frame(16'h0033, 16'h2222, 32, -1, 1'b1, 1'b1, GAP, rx);
        chk("rs2_reg", {16'd0, regs[8'h33]}, 32'h00002222);

        // 34 SCLK pulses in one write frame
        hi_base = miso_hi;
        spi_frame(16'h0077, 16'h5555, 34, -1, 1'b1, 1'b1, GAP, rx);
        chk("x34_wr", wr_cnt, 5);
        chk("x34_reg", {16'd0, regs[8'h77]}, 32'h00005555);
        chk("x34_miso", miso_hi - hi_base, 0);
        chk("x34_done", done_cnt, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
